pe_db_param: RTL and testbench

//  Parametrised systolic-array processing element with a registered datapath and double-buffered accumulators.

---
 rtl/pe_pkg.sv | 57 +++++
 rtl/pe_acc_bank.sv | 38 +++
 rtl/pe_db_param.sv | 145 ++++++++++++++
 tb/tb_pe_db_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the double-buffered systolic PE.
// acc_add clamps instead of wrapping when PE_SATURATE_EN is defined.
package pe_pkg;

  localparam logic PE_MODE_OS = 1'b0;
  localparam logic PE_MODE_WS = 1'b1;

  // Helpers work on a wide word; ACC_W must stay <= 62 for the clamp compare.
  localparam int PE_MAX_W = 64;
  typedef logic [PE_MAX_W-1:0] pe_word_t;
  localparam pe_word_t PE_ONES = '1;

  function automatic pe_word_t pe_ext(
    input pe_word_t v,
    input int       w,
    input logic     sgn
  );
    pe_word_t msk;
    msk = PE_ONES << w;
    if (sgn && v[6'(w-1)]) return v | msk;
    return v & ~msk;
  endfunction

  function automatic pe_word_t ext_prod(
    input pe_word_t a,
    input pe_word_t b,
    input int       wa,
    input int       wb,
    input logic     sgn
  );
    return pe_ext(a, wa, sgn) * pe_ext(b, wb, sgn);
  endfunction

  function automatic pe_word_t acc_add(
    input pe_word_t x,
    input pe_word_t y,
    input int       w,
    input logic     sgn
  );
    pe_word_t s;
    s = pe_ext(x, w, sgn) + pe_ext(y, w, sgn);
`ifdef PE_SATURATE_EN
    if (sgn) begin
      pe_word_t hi;
      pe_word_t lo;
      hi = (pe_word_t'(1) << (w-1)) - pe_word_t'(1);
      lo = ~hi;
      if ($signed(s) > $signed(hi)) s = hi;
      else if ($signed(s) < $signed(lo)) s = lo;
    end else if ((s >> w) != '0) begin
      s = ~(PE_ONES << w);
    end
`endif
    return s;
  endfunction

endpackage

// File: rtl/pe_acc_bank.sv
// Double-buffered accumulator pair with an active pointer.
// Writes address banks by the pointer value before any swap.
module pe_acc_bank #(
  parameter int ACC_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             swap,
  input  logic             wr_act,
  input  logic [ACC_W-1:0] wr_act_data,
  input  logic             wr_shadow,
  input  logic [ACC_W-1:0] wr_shadow_data,
  output logic [ACC_W-1:0] rd_act,
  output logic [ACC_W-1:0] rd_shadow
);

  logic [ACC_W-1:0] acc0_q;
  logic [ACC_W-1:0] acc1_q;
  logic             act_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc0_q <= '0;
      acc1_q <= '0;
      act_q  <= 1'b0;
    end else begin
      if (wr_act && !act_q) acc0_q <= wr_act_data;
      if (wr_act && act_q) acc1_q <= wr_act_data;
      if (wr_shadow && act_q) acc0_q <= wr_shadow_data;
      if (wr_shadow && !act_q) acc1_q <= wr_shadow_data;
      if (swap) act_q <= ~act_q;
    end
  end

  assign rd_act    = act_q ? acc1_q : acc0_q;
  assign rd_shadow = act_q ? acc0_q : acc1_q;

endmodule

// File: rtl/pe_db_param.sv
// Systolic PE: registered a/b forwarding, OS accumulate or WS psum forward.
// Define PE_SATURATE_EN for clamping adders instead of wrapping ones.
module pe_db_param
  import pe_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [IN_W-1:0]  io_in_a,
  input  logic [IN_W-1:0]  io_in_b,
  input  logic [ACC_W-1:0] io_in_d,
  input  logic             io_in_valid,
  input  logic             io_in_propagate,
  input  logic             io_in_mode,
  output logic [IN_W-1:0]  io_out_a,
  output logic [IN_W-1:0]  io_out_b,
  output logic [ACC_W-1:0] io_out_c,
  output logic             io_out_valid,
  output logic             io_out_propagate
);

  localparam logic SGN = (SIGNED != 0);

  logic [IN_W-1:0]  a_q;
  logic [IN_W-1:0]  b_q;
  logic [ACC_W-1:0] c_q;
  logic [ACC_W-1:0] c_d;
  logic             vld_q;
  logic             oprop_q;
  logic             prop_q;
  logic             mode_q;

  logic             toggle;
  logic [ACC_W-1:0] rd_act;
  logic [ACC_W-1:0] rd_shadow;
  logic [ACC_W-1:0] w_sel;
  logic [ACC_W-1:0] prod_ab;
  logic [ACC_W-1:0] b_ext;
  logic [ACC_W-1:0] ws_sum;
  logic [ACC_W-1:0] os_sum;
  logic [ACC_W-1:0] os_tog_sum;

  logic             swap;
  logic             wr_act;
  logic [ACC_W-1:0] wr_act_data;
  logic             wr_shadow;
  logic [ACC_W-1:0] wr_shadow_data;

  assign toggle = io_in_valid & (io_in_propagate != prop_q);

  assign prod_ab = ACC_W'(ext_prod(pe_word_t'(io_in_a),
                                   pe_word_t'(io_in_b),
                                   IN_W, IN_W, SGN));
  assign b_ext = ACC_W'(pe_ext(pe_word_t'(io_in_b), IN_W, SGN));

  // A toggle flips the pointer, so WS must already use the incoming weight.
  assign w_sel = toggle ? rd_shadow : rd_act;

  assign ws_sum = ACC_W'(acc_add(
    pe_word_t'(io_in_d),
    ext_prod(pe_word_t'(io_in_a), pe_word_t'(w_sel), IN_W, ACC_W, SGN),
    ACC_W, SGN));

  assign os_sum = ACC_W'(acc_add(pe_word_t'(rd_act),
                                 pe_word_t'(prod_ab), ACC_W, SGN));
  assign os_tog_sum = ACC_W'(acc_add(pe_word_t'(rd_shadow),
                                     pe_word_t'(prod_ab), ACC_W, SGN));

  always_comb begin
    c_d            = c_q;
    swap           = 1'b0;
    wr_act         = 1'b0;
    wr_act_data    = '0;
    wr_shadow      = 1'b0;
    wr_shadow_data = '0;
    if (toggle) begin
      swap = 1'b1;
      if (io_in_mode == PE_MODE_OS) begin
        c_d            = rd_act;
        wr_act         = 1'b1;
        wr_shadow      = 1'b1;
        wr_shadow_data = os_tog_sum;
      end else begin
        c_d = ws_sum;
      end
    end else if (io_in_valid) begin
      wr_shadow      = 1'b1;
      wr_shadow_data = (io_in_mode == PE_MODE_WS) ? b_ext : io_in_d;
      if (mode_q == PE_MODE_OS) begin
        wr_act      = 1'b1;
        wr_act_data = os_sum;
      end else begin
        c_d = ws_sum;
      end
    end
  end

  pe_acc_bank #(
    .ACC_W(ACC_W)
  ) u_bank (
    .clock         (clock),
    .reset_n       (reset_n),
    .swap          (swap),
    .wr_act        (wr_act),
    .wr_act_data   (wr_act_data),
    .wr_shadow     (wr_shadow),
    .wr_shadow_data(wr_shadow_data),
    .rd_act        (rd_act),
    .rd_shadow     (rd_shadow)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      vld_q   <= 1'b0;
      oprop_q <= 1'b0;
      prop_q  <= 1'b0;
      mode_q  <= PE_MODE_OS;
    end else if (io_in_valid) begin
      a_q     <= io_in_a;
      b_q     <= io_in_b;
      c_q     <= c_d;
      vld_q   <= 1'b1;
      oprop_q <= io_in_propagate;
      if (toggle) begin
        prop_q <= io_in_propagate;
        mode_q <= io_in_mode;
      end
    end else begin
      vld_q <= 1'b0;
    end
  end

  assign io_out_a         = a_q;
  assign io_out_b         = b_q;
  assign io_out_c         = c_q;
  assign io_out_valid     = vld_q;
  assign io_out_propagate = oprop_q;

endmodule

// File: tb/tb_pe_db_param.sv
// Directed bench for pe_db_param (IN_W=8, ACC_W=32, SIGNED=1).
// Reference model tracks two banks as an array; literals pin key results.
module tb_pe_db_param;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [31:0] d = '0;
  logic        v = 1'b0;
  logic        p = 1'b0;
  logic        m = 1'b0;

  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic [31:0] out_c;
  logic        out_v;
  logic        out_p;

  int n_chk = 0;
  int n_fail = 0;

  // Model state
  logic [31:0] bank [2];
  int          m_act;
  logic        m_prop;
  logic        m_mode;
  logic [7:0]  e_a;
  logic [7:0]  e_b;
  logic [31:0] e_c;
  logic        e_v;
  logic        e_p;

`ifdef PE_SATURATE_EN
  localparam logic [31:0] SAT_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] SAT_EXP = 32'h8000_3E01;
`endif

  pe_db_param #(
    .IN_W(8),
    .ACC_W(32),
    .SIGNED(1)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .io_in_a         (a),
    .io_in_b         (b),
    .io_in_d         (d),
    .io_in_valid     (v),
    .io_in_propagate (p),
    .io_in_mode      (m),
    .io_out_a        (out_a),
    .io_out_b        (out_b),
    .io_out_c        (out_c),
    .io_out_valid    (out_v),
    .io_out_propagate(out_p)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  function automatic logic [31:0] madd(input logic [31:0] x,
                                       input logic [31:0] y);
    longint s;
    s = longint'($signed(x)) + longint'($signed(y));
`ifdef PE_SATURATE_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  function automatic logic [31:0] mmul(input logic [7:0] x,
                                       input logic [31:0] y);
    longint r;
    r = longint'($signed(x)) * longint'($signed(y));
    return r[31:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    bank[0] = '0;
    bank[1] = '0;
    m_act   = 0;
    m_prop  = 1'b0;
    m_mode  = 1'b0;
    e_a = '0; e_b = '0; e_c = '0; e_v = 1'b0; e_p = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] prod;
    logic [31:0] sh;
    int nx;
    prod = mmul(a, {{24{b[7]}}, b});
    sh   = m ? {{24{b[7]}}, b} : d;
    if (!v) begin
      e_v = 1'b0;
    end else begin
      e_a = a; e_b = b; e_v = 1'b1; e_p = p;
      if (p != m_prop) begin
        nx     = 1 - m_act;
        m_prop = p;
        m_mode = m;
        if (!m) begin
          e_c      = bank[m_act];
          bank[nx] = madd(bank[nx], prod);
          bank[m_act] = '0;
        end else begin
          e_c = madd(d, mmul(a, bank[nx]));
        end
        m_act = nx;
      end else begin
        if (!m_mode) bank[m_act] = madd(bank[m_act], prod);
        else e_c = madd(d, mmul(a, bank[m_act]));
        bank[1-m_act] = sh;
      end
    end
  endtask

  task automatic compare_all();
    chk("out_a", 32'(out_a), 32'(e_a));
    chk("out_b", 32'(out_b), 32'(e_b));
    chk("out_c", out_c, e_c);
    chk("out_valid", 32'(out_v), 32'(e_v));
    chk("out_propagate", 32'(out_p), 32'(e_p));
  endtask

  task automatic cyc(input logic vv, input logic [7:0] aa,
                     input logic [7:0] bb, input logic [31:0] dd,
                     input logic pp, input logic mm);
    v = vv; a = aa; b = bb; d = dd; p = pp; m = mm;
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    v = 1'b0; a = '0; b = '0; d = '0; p = 1'b0; m = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_c", out_c, 32'h0);
    chk("rst_a", 32'(out_a), 32'h0);
    chk("rst_valid", 32'(out_v), 32'h0);
    chk("rst_prop", 32'(out_p), 32'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // OS accumulate then two toggles
    repeat (4) cyc(1, 8'd3, 8'd4, 32'd100, 0, 0);
    chk("t1_hold_c", out_c, 32'd0);
    cyc(1, 8'd1, 8'd1, 32'd100, 1, 0);
    chk("t1_c48", out_c, 32'd48);
    chk("t1_prop", 32'(out_p), 32'd1);
    cyc(1, 8'd1, 8'd1, 32'd0, 0, 0);
    chk("t1_c101", out_c, 32'd101);

    // WS weight preload, toggle, forward
    cyc(1, 8'd0, 8'hFE, 32'd0, 0, 1);
    chk("t2_b", 32'(out_b), 32'hFE);
    cyc(1, 8'd5, 8'h11, 32'd10, 1, 1);
    chk("t2_c0", out_c, 32'd0);
    cyc(1, 8'd3, 8'h22, 32'd7, 1, 1);
    chk("t2_c1", out_c, 32'd1);
    chk("t2_b22", 32'(out_b), 32'h22);

    // Bubbles with wiggling inputs
    cyc(0, 8'd9, 8'd8, 32'd55, 0, 0);
    cyc(0, 8'd7, 8'd6, 32'd66, 1, 1);
    cyc(0, 8'd5, 8'd4, 32'd77, 0, 0);
    chk("t3_valid", 32'(out_v), 32'd0);
    chk("t3_a", 32'(out_a), 32'd3);
    chk("t3_c", out_c, 32'd1);
    chk("t3_prop", 32'(out_p), 32'd1);
    cyc(1, 8'd2, 8'd0, 32'd0, 0, 0);
    chk("t3_tog_c", out_c, 32'hFFFF_FFFE);

    // Overflow of the toggle add
    cyc(1, 8'd0, 8'd0, 32'h7FFF_FF00, 0, 0);
    cyc(1, 8'd127, 8'd127, 32'd0, 1, 0);
    chk("t4_c34", out_c, 32'd34);
    cyc(1, 8'd0, 8'd0, 32'd0, 0, 0);
    chk("t4_sat", out_c, SAT_EXP);

    // Async reset between edges
    cyc(1, 8'd2, 8'd3, 32'd0, 0, 0);
    cyc(1, 8'd2, 8'd3, 32'd0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_c", out_c, 32'h0);
    chk("t5_async_a", 32'(out_a), 32'h0);
    chk("t5_async_v", 32'(out_v), 32'h0);
    model_reset();
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    cyc(1, 8'd1, 8'd1, 32'd0, 0, 0);
    chk("t5_no_tog", out_c, 32'd0);
    cyc(1, 8'd0, 8'd0, 32'd0, 1, 0);
    chk("t5_fresh", out_c, 32'd1);

    // Back-to-back toggles from reset
    do_reset();
    cyc(1, 8'd1, 8'd1, 32'd0, 0, 0);
    chk("t6_c0", out_c, 32'd0);
    cyc(1, 8'd1, 8'd1, 32'd0, 1, 0);
    chk("t6_c1", out_c, 32'd1);
    cyc(1, 8'd1, 8'd1, 32'd0, 0, 0);
    chk("t6_c2", out_c, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
